// File: rtl/link_game_pkg.sv
// link_game_pkg: shared state encoding, pixel widths and timing defaults for the link game frame controller.
package link_game_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int COL_W = 6;
  localparam int FRAME_CYCLES_DEF = 833334;
  localparam int WDOG_CYCLES_DEF = 65535;
  typedef enum logic [5:0] {
    S_INIT      = 6'b000001,
    S_IDLE      = 6'b000010,
    S_REG       = 6'b000100,
    S_APPLY     = 6'b001000,
    S_DRAW_MAP  = 6'b010000,
    S_DRAW_LINK = 6'b100000
  } state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running frame counter with pending-tick latch and saturating overrun count.
module frame_tick_gen import link_game_pkg::*; #(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_idle,
  input  logic       pause,
  input  logic       idle_exit,
  output logic       tick_pending,
  output logic [7:0] overrun_cnt
);
  localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          tick, hold;
  // a paused IDLE swallows ticks; otherwise a new tick beats the clear on IDLE exit
  always_comb begin
    tick = cnt_q == CW'(FRAME_CYCLES - 1);
    hold = in_idle && pause;
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    pend_d = hold ? pend_q && !tick : tick || (pend_q && !idle_exit);
    ovr_d = (tick && pend_q && !hold && !idle_exit && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  end
  assign tick_pending = pend_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: rtl/link_frame_ctrl.sv
// link_frame_ctrl: per-frame sequencer for the character/map draw phases with VGA pixel mux.
// Define LINK_FRAME_CTRL_WDOG_EN to enable the draw-phase watchdog and draw_timeout flag.
module link_frame_ctrl import link_game_pkg::*; #(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             map_draw_done,
  input  logic             link_draw_done,
  input  logic [X_W-1:0]   map_x,
  input  logic [Y_W-1:0]   map_y,
  input  logic [COL_W-1:0] map_colour,
  input  logic             map_write,
  input  logic [X_W-1:0]   link_x,
  input  logic [Y_W-1:0]   link_y,
  input  logic [COL_W-1:0] link_colour,
  input  logic             link_write,
  output logic             init,
  output logic             idle,
  output logic             reg_action,
  output logic             apply_action,
  output logic             draw_map,
  output logic             draw_link,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_write,
  output logic [7:0]       overrun_cnt,
  output logic             draw_timeout
);
  state_t state_q, state_d;
  logic   tick_pending, idle_exit, wd_hit;
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65536) begin : g_bad_wdog
    $error("WDOG_CYCLES must fit the 16-bit watchdog counter");
  end
  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clock(clock),
    .reset(reset),
    .in_idle(idle),
    .pause(pause),
    .idle_exit(idle_exit),
    .tick_pending(tick_pending),
    .overrun_cnt(overrun_cnt)
  );
`ifdef LINK_FRAME_CTRL_WDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        to_q, to_d;
  always_comb begin
    wd_hit = (draw_map || draw_link) && wd_q == 16'(WDOG_CYCLES - 1);
    wd_d = (draw_map || draw_link) && state_d == state_q ? wd_q + 16'd1 : '0;
    to_d = to_q || wd_hit;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
  assign draw_timeout = to_q;
`else
  assign wd_hit = 1'b0;
  assign draw_timeout = 1'b0;
`endif
  assign idle_exit = idle && tick_pending && !pause;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      state_d = S_IDLE;
      S_IDLE:      state_d = idle_exit ? S_REG : S_IDLE;
      S_REG:       state_d = S_APPLY;
      S_APPLY:     state_d = S_DRAW_MAP;
      S_DRAW_MAP:  state_d = map_draw_done || wd_hit ? S_DRAW_LINK : S_DRAW_MAP;
      S_DRAW_LINK: state_d = link_draw_done || wd_hit ? S_IDLE : S_DRAW_LINK;
      default:     state_d = S_INIT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_INIT;
    else state_q <= state_d;
  end
  assign init = state_q == S_INIT;
  assign idle = state_q == S_IDLE;
  assign reg_action = state_q == S_REG;
  assign apply_action = state_q == S_APPLY;
  assign draw_map = state_q == S_DRAW_MAP;
  assign draw_link = state_q == S_DRAW_LINK;
  assign vga_x = draw_map ? map_x : draw_link ? link_x : '0;
  assign vga_y = draw_map ? map_y : draw_link ? link_y : '0;
  assign vga_colour = draw_map ? map_colour : draw_link ? link_colour : '0;
  assign vga_write = draw_map ? map_write : draw_link ? link_write : 1'b0;
endmodule

// File: tb/tb_link_frame_ctrl.sv
// tb_link_frame_ctrl: directed scoreboard bench for link_frame_ctrl (FRAME_CYCLES=16, WDOG_CYCLES=20).
module tb_link_frame_ctrl;
  localparam int FC = 16;
  localparam int WC = 20;
  localparam logic [5:0] E_INIT = 6'b000001, E_IDLE = 6'b000010, E_REG = 6'b000100,
                         E_APP = 6'b001000, E_MAP = 6'b010000, E_LNK = 6'b100000;
  typedef struct {
    int         ph;
    int         t;
    logic [5:0] strb;
    logic [23:0] vga;
    logic [7:0] ovr;
    logic       to;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, pause = 1'b0, map_draw_done = 1'b0, link_draw_done = 1'b0;
  logic [8:0] map_x, link_x, vga_x;
  logic [7:0] map_y, link_y, vga_y;
  logic [5:0] map_colour, link_colour, vga_colour;
  logic map_write = 1'b1, link_write = 1'b1, vga_write;
  logic init, idle, reg_action, apply_action, draw_map, draw_link, draw_timeout;
  logic [7:0] overrun_cnt;
  exp_t q[$];
  int t = 0, ph = 0, total = 0, bad = 0;
  logic [7:0] exp_ovr = 8'd0;
  logic exp_to = 1'b0;
  always #5 clock = ~clock;
  link_frame_ctrl #(.FRAME_CYCLES(FC), .WDOG_CYCLES(WC)) dut (
    .clock(clock), .reset(reset), .pause(pause),
    .map_draw_done(map_draw_done), .link_draw_done(link_draw_done),
    .map_x(map_x), .map_y(map_y), .map_colour(map_colour), .map_write(map_write),
    .link_x(link_x), .link_y(link_y), .link_colour(link_colour), .link_write(link_write),
    .init(init), .idle(idle), .reg_action(reg_action), .apply_action(apply_action),
    .draw_map(draw_map), .draw_link(draw_link),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
    .overrun_cnt(overrun_cnt), .draw_timeout(draw_timeout)
  );
  task automatic drive_pix();
    map_x = 9'(t * 5 + 1);
    map_y = 8'(t + 3);
    map_colour = 6'(t * 7);
    link_x = 9'(511 - t);
    link_y = 8'(t * 2 + 100);
    link_colour = 6'(63 - t);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    t++;
    drive_pix();
  endtask
  task automatic go_to(input int target);
    while (t < target) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    t = 0;
    drive_pix();
    exp_ovr = 8'd0;
    exp_to = 1'b0;
  endtask
  task automatic chk(input logic [5:0] s);
    exp_t e;
    e.ph = ph;
    e.t = t;
    e.strb = s;
    e.vga = s == E_MAP ? {map_x, map_y, map_colour, map_write} :
            s == E_LNK ? {link_x, link_y, link_colour, link_write} : 24'd0;
    e.ovr = exp_ovr;
    e.to = exp_to;
    q.push_back(e);
  endtask
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [5:0] gs;
      logic [23:0] gv;
      e = q.pop_front();
      gs = {draw_link, draw_map, apply_action, reg_action, idle, init};
      gv = {vga_x, vga_y, vga_colour, vga_write};
      total += 4;
      if (gs !== e.strb) begin
        bad++;
        $display("FAIL strobes ph%0d t%0d got=%b exp=%b", e.ph, e.t, gs, e.strb);
      end
      if (gv !== e.vga) begin
        bad++;
        $display("FAIL vga ph%0d t%0d got=%h exp=%h", e.ph, e.t, gv, e.vga);
      end
      if (overrun_cnt !== e.ovr) begin
        bad++;
        $display("FAIL overrun ph%0d t%0d got=%0d exp=%0d", e.ph, e.t, overrun_cnt, e.ovr);
      end
      if (draw_timeout !== e.to) begin
        bad++;
        $display("FAIL timeout ph%0d t%0d got=%b exp=%b", e.ph, e.t, draw_timeout, e.to);
      end
    end
  end
  initial begin
    drive_pix();
    ph = 1;
    do_reset();
    chk(E_INIT);
    for (int k = 1; k <= 18; k++) begin
      step();
      map_draw_done = (t == 5);
      link_draw_done = (t == 5);
      chk(k == 17 ? E_REG : k == 18 ? E_APP : E_IDLE);
    end
    ph = 2;
    for (int k = 19; k <= 27; k++) begin
      step();
      map_draw_done = (t == 21);
      link_draw_done = (t == 26);
      chk(t <= 21 ? E_MAP : t <= 26 ? E_LNK : E_IDLE);
    end
    ph = 3;
    go_to(32); chk(E_IDLE);
    step(); chk(E_REG);
    step(); chk(E_APP);
    step(); map_draw_done = 1'b1; chk(E_MAP);
    step(); map_draw_done = 1'b0; chk(E_LNK);
    go_to(48); chk(E_LNK);
    go_to(64); exp_ovr = 8'd1; chk(E_LNK);
    go_to(75); link_draw_done = 1'b1; chk(E_LNK);
    step(); link_draw_done = 1'b0; chk(E_IDLE);
    step(); chk(E_REG);
    step(); chk(E_APP);
    step(); map_draw_done = 1'b1; chk(E_MAP);
    step(); map_draw_done = 1'b0; chk(E_LNK);
    go_to(2000); exp_ovr = 8'd121; chk(E_LNK);
    go_to(4880); exp_ovr = 8'd255; link_draw_done = 1'b1; chk(E_LNK);
    step(); link_draw_done = 1'b0; chk(E_IDLE);
    step(); chk(E_REG);
    step(); chk(E_APP);
    step(); map_draw_done = 1'b1; chk(E_MAP);
    step(); map_draw_done = 1'b0; chk(E_LNK);
    step(); chk(E_LNK);
    ph = 4;
    do_reset();
    chk(E_INIT);
    ph = 5;
    pause = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      pause = (t < 49);
      if (t == 1 || t == 16 || t == 32 || t == 48 || t == 50) chk(E_IDLE);
    end
    go_to(64); chk(E_IDLE);
    step(); chk(E_REG);
    ph = 6;
    step(); chk(E_APP);
    step(); chk(E_MAP);
    go_to(80); map_draw_done = 1'b1; chk(E_MAP);
    step(); map_draw_done = 1'b0; link_draw_done = 1'b1; pause = 1'b1; chk(E_LNK);
    step(); link_draw_done = 1'b0; chk(E_IDLE);
    go_to(95); pause = 1'b0; chk(E_IDLE);
    step(); chk(E_REG);
    step(); chk(E_APP);
    step(); map_draw_done = 1'b1; chk(E_MAP);
    step(); map_draw_done = 1'b0; link_draw_done = 1'b1; chk(E_LNK);
    step(); link_draw_done = 1'b0; chk(E_IDLE);
    step(); chk(E_REG);
    ph = 7;
    step(); chk(E_APP);
    step(); chk(E_MAP);
`ifdef LINK_FRAME_CTRL_WDOG_EN
    go_to(122); chk(E_MAP);
    step(); exp_to = 1'b1; chk(E_LNK);
    go_to(130); exp_ovr = 8'd1; chk(E_LNK);
`else
    go_to(140); exp_ovr = 8'd1; chk(E_MAP);
`endif
    ph = 8;
    do_reset();
    chk(E_INIT);
    step(); chk(E_IDLE);
    step();
    step();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
